// File: rtl/crypt_pkg.sv
// Shared widths, FSM states and index type for the crypt block framer.
package crypt_pkg;
  localparam int unsigned BLK_BYTES = 16;
  localparam int unsigned KEY_W     = 10;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BLK_W     = BLK_BYTES * BYTE_W;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [IDX_W-1:0] byte_idx_t;
endpackage

// File: rtl/crypt_byte_piso.sv
// 16-byte parallel-load, byte-serial shift-out; byte 0 (bits 0..7) leaves first.
module crypt_byte_piso
  import crypt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [0:BLK_W-1]  load_data,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done_c
);

  logic [0:BLK_W-1] res_q, res_d;
  logic             valid_q, valid_d;
  byte_idx_t        idx_q, idx_d;
  logic             take_c;

  assign take_c    = valid_q && out_ready;
  assign done_c    = take_c && (idx_q == byte_idx_t'(BLK_BYTES - 1));
  assign out_data  = res_q[0:BYTE_W-1];
  assign out_valid = valid_q;

  // Load a fresh result, or shift one byte out per accepted handshake.
  always_comb begin
    res_d   = res_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (load) begin
      res_d   = load_data;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (take_c) begin
      res_d = {res_q[BYTE_W:BLK_W-1], {BYTE_W{1'b0}}};
      idx_d = idx_q + byte_idx_t'(1);
      if (idx_q == byte_idx_t'(BLK_BYTES - 1)) begin
        valid_d = 1'b0;
      end
    end
  end

  // Result register, valid flag and byte index.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/crypt_block_framer.sv
// Byte-stream framer around the combinational 16-byte crypt core: fill, settle, drain.
module crypt_block_framer
  import crypt_pkg::*;
#(
  parameter int unsigned CORE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:KEY_W-1]  cfg_key,
  input  logic              cfg_mode,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:BLK_W-1]  core_block,
  output logic [0:KEY_W-1]  core_key,
  output logic              core_mode,
  input  logic [0:BLK_W-1]  core_res_enc,
  input  logic [0:BLK_W-1]  core_res_dec,
  output logic              busy
);

  localparam logic [3:0] LAT = 4'(CORE_LAT);

  state_t           state_q, state_d;
  byte_idx_t        cnt_q, cnt_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [0:BLK_W-1] core_block_q, core_block_d;
  logic [0:KEY_W-1] core_key_q, core_key_d;
  logic             core_mode_q, core_mode_d;
  logic             piso_load_c;
  logic             piso_valid;
  logic             piso_done_c;
  logic [0:BLK_W-1] piso_data_c;

  assign piso_data_c = core_mode_q ? core_res_dec : core_res_enc;

  // Handshake levels come from registered state; all forced low while in reset.
  assign in_ready   = !rst && (state_q == FILL);
  assign cfg_ready  = !rst && (state_q == FILL) && (cnt_q == '0);
  assign busy       = !rst && ((state_q == WAIT) || (state_q == DRAIN));
  assign out_valid  = !rst && piso_valid;
  assign core_block = core_block_q;
  assign core_key   = core_key_q;
  assign core_mode  = core_mode_q;

  // Next-state: byte assembly in FILL, settle countdown in WAIT, hand-off in DRAIN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_cnt_d   = wait_cnt_q;
    core_block_d = core_block_q;
    core_key_d   = core_key_q;
    core_mode_d  = core_mode_q;
    piso_load_c  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (cfg_valid && (cnt_q == '0)) begin
          core_key_d  = cfg_key;
          core_mode_d = cfg_mode;
        end
        if (in_valid) begin
          core_block_d[{cnt_q, 3'b000} +: BYTE_W] = in_data;
          if (cnt_q == byte_idx_t'(BLK_BYTES - 1)) begin
            state_d    = WAIT;
            cnt_d      = '0;
            wait_cnt_d = LAT;
          end else begin
            cnt_d = cnt_q + byte_idx_t'(1);
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          piso_load_c = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (piso_done_c) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, counters and core-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      wait_cnt_q   <= '0;
      core_block_q <= '0;
      core_key_q   <= '0;
      core_mode_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      core_block_q <= core_block_d;
      core_key_q   <= core_key_d;
      core_mode_q  <= core_mode_d;
    end
  end

  crypt_byte_piso u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (piso_load_c),
    .load_data (piso_data_c),
    .out_data  (out_data),
    .out_valid (piso_valid),
    .out_ready (out_ready),
    .done_c    (piso_done_c)
  );

endmodule

// File: tb/tb_crypt_block_framer.sv
// Randomized bench for crypt_block_framer: two instances (CORE_LAT 1 and 3) with stub cores.
module tb_crypt_block_framer;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0][0:9]   cfg_key   = '0;
  logic [1:0]        cfg_mode  = '0;
  logic [1:0]        cfg_valid = '0;
  logic [1:0]        cfg_ready;
  logic [1:0][7:0]   in_data   = '0;
  logic [1:0]        in_valid  = '0;
  logic [1:0]        in_ready;
  logic [1:0][7:0]   out_data;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready = '0;
  logic [1:0][0:127] core_block;
  logic [1:0][0:9]   core_key;
  logic [1:0]        core_mode;
  logic [1:0][0:127] res_enc, res_dec;
  logic [1:0]        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model of the loaded cfg per unit.
  logic [1:0][9:0] mk = '0;
  logic [1:0]      mm = '0;
  int              lat_of [2] = '{1, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub cores: q_k = byte_k ^ 5A, v_k = byte_k ^ A5.
  assign res_enc[0] = core_block[0] ^ {16{8'h5A}};
  assign res_dec[0] = core_block[0] ^ {16{8'hA5}};
  assign res_enc[1] = core_block[1] ^ {16{8'h5A}};
  assign res_dec[1] = core_block[1] ^ {16{8'hA5}};

  crypt_block_framer #(.CORE_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cfg_key(cfg_key[0]), .cfg_mode(cfg_mode[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .core_block(core_block[0]), .core_key(core_key[0]), .core_mode(core_mode[0]),
    .core_res_enc(res_enc[0]), .core_res_dec(res_dec[0]), .busy(busy[0])
  );

  crypt_block_framer #(.CORE_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cfg_key(cfg_key[1]), .cfg_mode(cfg_mode[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .core_block(core_block[1]), .core_key(core_key[1]), .core_mode(core_mode[1]),
    .core_res_enc(res_enc[1]), .core_res_dec(res_dec[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reset both units for 3 cycles and check levels during and after.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0; cfg_valid = '0; out_ready = '0;
    mk = '0; mm = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        check("rst_in_ready", in_ready[u], 0);
        check("rst_out_valid", out_valid[u], 0);
        check("rst_busy", busy[u], 0);
        check("rst_cfg_ready", cfg_ready[u], 0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("post_rst_in_ready", in_ready[u], 1);
      check("post_rst_cfg_ready", cfg_ready[u], 1);
      check("post_rst_core_block", core_block[u], 0);
      check("post_rst_core_key", core_key[u], 0);
      check("post_rst_out_data", out_data[u], 0);
    end
  endtask

  // One block through unit u. base<0: random bytes. rdy_pat 0=always,1=toggle,2=random.
  // cfg_at: byte index at which cfg_valid is raised (-1 none). abort_at: reset after that many outputs.
  task automatic run_block(input int u, input int base, input int rdy_pat, input bit gaps,
                           input int cfg_at, input logic [9:0] key, input logic mode,
                           input int abort_at);
    logic [7:0]   blk [16];
    logic [0:127] exp_blk;
    logic [7:0]   prev;
    bit           cfg_done, seen, stalled, tog;
    int           k, got, c_last, guard, lat;
    lat = lat_of[u];
    for (int i = 0; i < 16; i++) begin
      blk[i] = (base >= 0) ? 8'(base + i) : 8'($urandom);
      exp_blk[8*i +: 8] = blk[i];
    end
    k = 0; guard = 0; cfg_done = 0; c_last = 0;
    while (k < 16 && guard < 200) begin
      @(negedge clk);
      guard++;
      check("fill_in_ready", in_ready[u], 1);
      check("fill_cfg_ready", cfg_ready[u], k == 0);
      check("fill_busy", busy[u], 0);
      in_valid[u] = !gaps || ($urandom_range(0, 2) != 0);
      cfg_valid[u] = 1'b0;
      cfg_key[u] = 10'($urandom);
      cfg_mode[u] = 1'($urandom);
      if (!cfg_done && cfg_at == k) begin
        cfg_valid[u] = 1'b1;
        cfg_key[u] = key;
        cfg_mode[u] = mode;
        in_valid[u] = 1'b1;
        cfg_done = 1;
        if (k == 0) begin
          mk[u] = key;
          mm[u] = mode;
        end
      end
      in_data[u] = in_valid[u] ? blk[k] : 8'($urandom);
      if (in_valid[u]) begin
        if (k == 15) c_last = cyc;
        k++;
      end
      @(posedge clk);
    end
    if (k < 16) check("fill_timeout", 0, 1);
    got = 0; guard = 0; seen = 0; stalled = 0; tog = 1; prev = '0;
    while (got < 16 && guard < 400 && !(abort_at >= 0 && got == abort_at)) begin
      @(negedge clk);
      guard++;
      in_valid[u] = 1'b0;
      cfg_valid[u] = 1'b0;
      check("busy_in_ready", in_ready[u], 0);
      check("busy_flag", busy[u], 1);
      check("busy_cfg_ready", cfg_ready[u], 0);
      check("core_block", core_block[u], exp_blk);
      check("core_key", core_key[u], mk[u]);
      check("core_mode", core_mode[u], mm[u]);
      if (out_valid[u]) begin
        if (!seen) begin
          seen = 1;
          check("first_valid_latency", cyc - c_last, lat + 1);
        end
        if (stalled) check("stall_hold", out_data[u], prev);
        case (rdy_pat)
          0: out_ready[u] = 1'b1;
          1: begin out_ready[u] = tog; tog = !tog; end
          default: out_ready[u] = 1'($urandom);
        endcase
        if (out_ready[u]) begin
          check("out_byte", out_data[u], blk[got] ^ (mm[u] ? 8'hA5 : 8'h5A));
          if (got == 15 && rdy_pat == 0) check("last_byte_cycle", cyc - c_last, lat + 16);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev = out_data[u];
        end
      end else begin
        check("valid_dropped", seen, 0);
        out_ready[u] = 1'($urandom);
      end
      @(posedge clk);
    end
    if (abort_at >= 0 && got == abort_at) begin
      @(negedge clk);
      rst = 1'b1;
      out_ready[u] = 1'b0;
      mk = '0; mm = '0;
      #1;
      check("rst_drain_valid", out_valid[u], 0);
      @(negedge clk);
      check("rst_drain_valid_next", out_valid[u], 0);
      check("rst_drain_busy", busy[u], 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_drain_in_ready", in_ready[u], 1);
      check("rst_drain_out_valid", out_valid[u], 0);
      check("rst_drain_cfg_ready", cfg_ready[u], 1);
      return;
    end
    if (got < 16) check("drain_timeout", got, 16);
    @(negedge clk);
    out_ready[u] = 1'b0;
    check("done_in_ready", in_ready[u], 1);
    check("done_out_valid", out_valid[u], 0);
    check("done_busy", busy[u], 0);
  endtask

  initial begin
    do_reset();
    // Mode 0 at CORE_LAT 1 with a fresh key.
    run_block(0, 0, 0, 0, 0, 10'h2AB, 1'b0, -1);
    check("key_2ab", core_key[0], 10'h2AB);
    // Mode 1 at CORE_LAT 3.
    run_block(1, 0, 0, 0, 0, 10'h0F3, 1'b1, -1);
    // Toggling out_ready.
    run_block(0, -1, 1, 0, -1, 10'h000, 1'b0, -1);
    // Mid-block cfg ignored, then reload with first byte takes effect.
    run_block(0, -1, 0, 0, 5, 10'h155, 1'b1, -1);
    run_block(0, -1, 0, 0, 0, 10'h155, 1'b1, -1);
    check("key_155", core_key[0], 10'h155);
    // Reset during DRAIN after 7 bytes, then a clean block.
    run_block(1, -1, 0, 0, 0, 10'h3C3, 1'b1, 7);
    run_block(1, 16, 0, 0, 0, 10'h1E1, 1'b0, -1);
    // Randomized blocks on both units.
    for (int b = 0; b < 10; b++) begin
      int ca;
      ca = $urandom_range(0, 2) == 0 ? -1 : int'($urandom_range(0, 15));
      run_block(b % 2, -1, $urandom_range(0, 2), 1'($urandom), ca,
                10'($urandom), 1'($urandom), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/crypt_block_framer.md
# crypt_block_framer

Byte-stream front/back end for the combinational 16-byte crypt core (Encryptor/Decryptor pair, 10-bit key, mode select).
- Collects 16 input bytes into the core's 4x4 block, holds block/key/mode stable for a fixed settling time, then captures the mode-selected result.
- Streams the result back out one byte at a time.
- Sits directly upstream and downstream of the crypt core, between it and the byte-wide host/DMA path.

## Interface
Parameters:
- CORE_LAT, 1: cycles the core inputs are held before the result is captured; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_key  in  [0:9]  key for the next block.
- cfg_mode  in  1  0 = encrypt (core q outputs), 1 = decrypt (core v outputs).
- cfg_valid  in  1  key/mode load request.
- cfg_ready  out  1  high only in FILL with byte count 0.
- in_data  in  [7:0]  plaintext/ciphertext byte.
- in_valid  in  1  input byte qualifier.
- in_ready  out  1  high only in FILL.
- out_data  out  [7:0]  result byte.
- out_valid  out  1  high only in DRAIN.
- out_ready  in  1  sink accepts byte.
- core_block  out  [0:127]  registered block to core; byte k is bits 8k..8k+7.
- core_key  out  [0:9]  registered key to core.
- core_mode  out  1  registered mode to core.
- core_res_enc  in  [0:127]  core q0..q15, byte k at bits 8k..8k+7.
- core_res_dec  in  [0:127]  core v0..v15, same packing.
- busy  out  1  high in WAIT or DRAIN.

## Operation
- Byte order: stream byte k maps to core byte k in the order a0,a1,a2,a3,b0..b3,c0..c3,d0..d3. in_data[7] maps to bit 0 (MSB) of the byte.
- Result order: output byte k = q_k (mode 0) or v_k (mode 1).
- cfg_valid && cfg_ready loads core_key/core_mode. A cfg load and the first byte in the same cycle are both accepted; the new cfg applies to that block. Otherwise cfg_valid is ignored, and the last loaded cfg persists across blocks.
- FILL: each in_valid && in_ready writes the byte at index cnt and increments cnt. The accept with cnt = 15 moves to WAIT, clears cnt, and loads wait_cnt = CORE_LAT.
- WAIT: decrement wait_cnt each cycle. In the cycle wait_cnt = 1, register the selected 128-bit result into res_reg and move to DRAIN. core_block/core_key/core_mode stay unchanged throughout WAIT.
- DRAIN: out_data = res_reg byte cnt. Each out_valid && out_ready increments cnt. The accept with cnt = 15 returns to FILL with cnt = 0.
- No overlap: in_ready is 0 in WAIT and DRAIN.
- Reset values: state FILL, cnt 0, wait_cnt 0, res_reg 0, core_block 0, core_key 0, core_mode 0, out_data 0.
- Output levels while rst is high: out_valid 0, in_ready 0, cfg_ready 0, busy 0.
- Reset mid-operation: block, result and counters are discarded; no partial output.

## Timing
- Last input handshake at cycle T: core_block updated at edge T+1; result captured at the end of cycle T+CORE_LAT.
- First out_valid at cycle T+CORE_LAT+1. With out_ready held high, the last byte goes out at T+CORE_LAT+16.
- in_ready returns high the cycle after the last output handshake.
- Full-rate input: 16 consecutive cycles fill a block.
- out_data/out_valid stay stable while out_ready is low.
- All outputs are registered or decoded from registered state only; there are no combinational paths from in_* to out_*.

## Structure
- Package crypt_pkg holds:
  - BLK_BYTES = 16, KEY_W = 10, BYTE_W = 8;
  - state enum {FILL, WAIT, DRAIN};
  - 4-bit byte-index typedef.
- One sub-module, crypt_byte_piso: a 16-byte parallel-load, byte-serial shift-out with valid/ready, used for the DRAIN path.
- Input assembly and the FSM stay in the top.

## Test plan
- Use a stub core with q_k = byte_k ^ 0x5A and v_k = byte_k ^ 0xA5.
1. Reset: hold rst 3 cycles, then release -> while rst high in_ready = 0, out_valid = 0, busy = 0; first cycle after release in_ready = 1, cfg_ready = 1, core_block = 0.
2. cfg key 10'h2AB, mode 0, bytes 0x00..0x0F, out_ready = 1, CORE_LAT = 1 -> core_key = 10'h2AB; outputs 0x5A,0x5B..0x55 in order; first out_valid 2 cycles after last input.
3. Same bytes, mode 1, CORE_LAT = 3 -> outputs 0xA5,0xA4..0xAA; first out_valid 4 cycles after last input; core_block stable during WAIT.
4. out_ready toggles 1/0 each cycle -> all 16 bytes in order with no drop or duplicate; out_data stable while stalled; in_ready stays 0 until the last accept.
5. cfg_valid with key 10'h155 at cnt = 5 -> cfg_ready = 0 and core_key unchanged for this block. A reload at cnt = 0 of the next block, simultaneous with its first byte, takes effect for that block.
6. rst pulse during DRAIN after 7 bytes out -> out_valid = 0 next cycle, in_ready = 1 after release; next block 0x10..0x1F mode 0 yields 0x4A..0x45 cleanly.
